// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use bubble insertion, imem/dmem wait freezing and stall perf counters
//   clk, rst_n                       : clock, asynchronous active-low reset
//   id_rs1_num/id_rs2_num/id_uses_*  : source operands of the ID instruction
//   id_is_store                      : ID instruction is a store (rs2 is store data)
//   ex_rd_num/ex_load_regfile/ex_is_load : destination info of the EX instruction
//   mem_dmem_req/dmem_resp           : data memory handshake seen in MEM
//   if_imem_req/imem_resp            : instruction memory handshake seen in IF
//   perf_clr                         : synchronous clear of both counters
//   stall_if/stall_id/bubble_id/bubble_ex/stall_mem : pipeline control
//   state                            : 0 RUN, 1 LU_BUBBLE, 2 DMEM_WAIT
//   load_use_cnt/mem_stall_cnt       : saturating stall-cycle counters
module hazard_stall_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_num,
  input  logic [4:0]       id_rs2_num,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_is_store,
  input  logic [4:0]       ex_rd_num,
  input  logic             ex_load_regfile,
  input  logic             ex_is_load,
  input  logic             mem_dmem_req,
  input  logic             dmem_resp,
  input  logic             if_imem_req,
  input  logic             imem_resp,
  input  logic             perf_clr,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_id,
  output logic             bubble_ex,
  output logic             stall_mem,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt
);
  typedef enum logic [1:0] {RUN = 2'd0, LU_BUBBLE = 2'd1, DMEM_WAIT = 2'd2} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d, ms_cnt_q, ms_cnt_d;
  logic dmem_stall, imem_stall, lu_hit;
  logic s_if, s_id, b_id, b_ex, s_mem;
  assign dmem_stall = mem_dmem_req & ~dmem_resp;
  assign imem_stall = if_imem_req & ~imem_resp;
  // rs2 of a store is only store data, which WB->MEM forwarding delivers in time
  assign lu_hit = ex_is_load & ex_load_regfile & (ex_rd_num != 5'd0) &
                  ((id_uses_rs1 & (id_rs1_num == ex_rd_num)) |
                   (id_uses_rs2 & (id_rs2_num == ex_rd_num) & ~id_is_store));
  always_comb begin
    state_d = state_q;
    s_if = 1'b0;
    s_id = 1'b0;
    b_id = 1'b0;
    b_ex = 1'b0;
    s_mem = 1'b0;
    case (state_q)
      RUN, LU_BUBBLE: begin
        // in LU_BUBBLE EX holds the inserted NOP, so detection is suppressed
        if (dmem_stall) begin
          s_mem = 1'b1;
          s_if = 1'b1;
          s_id = 1'b1;
          state_d = DMEM_WAIT;
        end else if (lu_hit && state_q == RUN) begin
          s_if = 1'b1;
          s_id = 1'b1;
          b_ex = 1'b1;
          state_d = LU_BUBBLE;
        end else begin
          s_if = imem_stall;
          b_id = imem_stall;
          state_d = RUN;
        end
      end
      DMEM_WAIT: begin
        // other hazards wait for the first RUN cycle
        s_mem = dmem_stall;
        s_if = dmem_stall;
        s_id = dmem_stall;
        state_d = dmem_stall ? DMEM_WAIT : RUN;
      end
      default: state_d = RUN;
    endcase
    lu_cnt_d = perf_clr ? '0 : (b_ex && !(&lu_cnt_q)) ? lu_cnt_q + CNT_W'(1) : lu_cnt_q;
    ms_cnt_d = perf_clr ? '0 : (s_mem && !(&ms_cnt_q)) ? ms_cnt_q + CNT_W'(1) : ms_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      lu_cnt_q <= '0;
      ms_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      lu_cnt_q <= lu_cnt_d;
      ms_cnt_q <= ms_cnt_d;
    end
  end
  // controls must read inactive for the whole time reset is held
  assign stall_if = rst_n & s_if;
  assign stall_id = rst_n & s_id;
  assign bubble_id = rst_n & b_id;
  assign bubble_ex = rst_n & b_ex;
  assign stall_mem = rst_n & s_mem;
  assign state = state_q;
  assign load_use_cnt = lu_cnt_q;
  assign mem_stall_cnt = ms_cnt_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed and swept stimulus checked against a behavioural model
module tb_hazard_stall_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1_num, id_rs2_num, ex_rd_num;
  logic id_uses_rs1, id_uses_rs2, id_is_store, ex_load_regfile, ex_is_load;
  logic mem_dmem_req, dmem_resp, if_imem_req, imem_resp, perf_clr;
  logic stall_if, stall_id, bubble_id, bubble_ex, stall_mem;
  logic [1:0] state;
  logic [CNT_W-1:0] load_use_cnt, mem_stall_cnt;
  int n_pass = 0;
  int n_total = 0;
  always #5 clk = ~clk;
  hazard_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_num(id_rs1_num), .id_rs2_num(id_rs2_num),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_store(id_is_store),
    .ex_rd_num(ex_rd_num), .ex_load_regfile(ex_load_regfile), .ex_is_load(ex_is_load),
    .mem_dmem_req(mem_dmem_req), .dmem_resp(dmem_resp),
    .if_imem_req(if_imem_req), .imem_resp(imem_resp), .perf_clr(perf_clr),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_id(bubble_id),
    .bubble_ex(bubble_ex), .stall_mem(stall_mem), .state(state),
    .load_use_cnt(load_use_cnt), .mem_stall_cnt(mem_stall_cnt)
  );
  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  // model: "waiting" = previous cycle had an unanswered dmem request,
  // "bubbled" = previous cycle already spent the one bubble for a load-use hazard
  bit m_wait = 0;
  bit m_bub = 0;
  int m_lu = 0;
  int m_ms = 0;
  always @(negedge clk) begin : model
    bit dm, im, lu;
    int e_sif, e_sid, e_bid, e_bex, e_smem, e_st;
    if (!rst_n) begin
      check("rst stall_if", stall_if, 0);
      check("rst stall_id", stall_id, 0);
      check("rst bubble_id", bubble_id, 0);
      check("rst bubble_ex", bubble_ex, 0);
      check("rst stall_mem", stall_mem, 0);
      check("rst state", state, 0);
      check("rst load_use_cnt", load_use_cnt, 0);
      check("rst mem_stall_cnt", mem_stall_cnt, 0);
      m_wait = 0;
      m_bub = 0;
      m_lu = 0;
      m_ms = 0;
    end else begin
      dm = mem_dmem_req && !dmem_resp;
      im = if_imem_req && !imem_resp;
      lu = ex_is_load && ex_load_regfile && ex_rd_num != 0 &&
           ((id_uses_rs1 && id_rs1_num == ex_rd_num) ||
            (id_uses_rs2 && id_rs2_num == ex_rd_num && !id_is_store));
      e_st = m_wait ? 2 : m_bub ? 1 : 0;
      e_sif = 0; e_sid = 0; e_bid = 0; e_bex = 0; e_smem = 0;
      if (m_wait || dm) begin
        e_smem = dm; e_sif = dm; e_sid = dm;
      end else if (lu && !m_bub) begin
        e_sif = 1; e_sid = 1; e_bex = 1;
      end else if (im) begin
        e_sif = 1; e_bid = 1;
      end
      check("stall_if", stall_if, e_sif);
      check("stall_id", stall_id, e_sid);
      check("bubble_id", bubble_id, e_bid);
      check("bubble_ex", bubble_ex, e_bex);
      check("stall_mem", stall_mem, e_smem);
      check("state", state, e_st);
      check("load_use_cnt", load_use_cnt, m_lu);
      check("mem_stall_cnt", mem_stall_cnt, m_ms);
      m_bub = e_bex != 0;
      m_wait = dm;
      m_lu = perf_clr ? 0 : (e_bex != 0 && m_lu < CMAX) ? m_lu + 1 : m_lu;
      m_ms = perf_clr ? 0 : (e_smem != 0 && m_ms < CMAX) ? m_ms + 1 : m_ms;
    end
  end
  task automatic idle();
    id_rs1_num = 0; id_rs2_num = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_is_store = 0;
    ex_rd_num = 0; ex_load_regfile = 0; ex_is_load = 0;
    mem_dmem_req = 0; dmem_resp = 0; if_imem_req = 0; imem_resp = 0; perf_clr = 0;
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic load_in_ex(input int rd);
    ex_is_load = 1; ex_load_regfile = 1; ex_rd_num = 5'(rd);
  endtask
  task automatic clear_counters();
    idle();
    perf_clr = 1;
    tick();
    perf_clr = 0;
  endtask
  initial begin
    rst_n = 0;
    idle();
    tick(2);
    rst_n = 1;
    tick();
    // load-use: lw x5 then add using x5 as rs1
    load_in_ex(5); id_uses_rs1 = 1; id_rs1_num = 5;
    #1;
    check("lu c0 bubble_ex", bubble_ex, 1);
    check("lu c0 stall_if", stall_if, 1);
    tick();
    check("lu c1 state", state, 1);
    check("lu c1 bubble_ex", bubble_ex, 0);
    check("lu c1 stall_id", stall_id, 0);
    idle();
    tick();
    check("lu state back", state, 0);
    check("lu count", load_use_cnt, 1);
    clear_counters();
    // store whose only dependency is store data: no stall
    load_in_ex(7); id_is_store = 1; id_uses_rs1 = 1; id_rs1_num = 2; id_uses_rs2 = 1; id_rs2_num = 7;
    #1;
    check("store rs2 no stall", stall_id, 0);
    tick(2);
    check("store rs2 count", load_use_cnt, 0);
    id_rs1_num = 7;
    #1;
    check("store rs1 bubble", bubble_ex, 1);
    tick(2);
    idle();
    tick();
    check("store rs1 count", load_use_cnt, 1);
    // x0 destination never stalls
    load_in_ex(0); id_uses_rs1 = 1; id_rs1_num = 0;
    #1;
    check("x0 no stall", stall_if, 0);
    tick();
    // imem stall only
    idle(); if_imem_req = 1;
    #1;
    check("imem bubble_id", bubble_id, 1);
    imem_resp = 1;
    #1;
    check("imem single-cycle", stall_if, 0);
    tick();
    // load-use while imem stalled: IF/ID held, no IF bubble
    idle(); if_imem_req = 1; load_in_ex(3); id_uses_rs2 = 1; id_rs2_num = 3;
    #1;
    check("lu+imem bubble_id", bubble_id, 0);
    tick();
    check("lu_bubble imem bubble_id", bubble_id, 1);
    idle();
    tick();
    clear_counters();
    // dmem wait of three cycles
    mem_dmem_req = 1;
    tick();
    check("dmem c1 state", state, 2);
    tick(2);
    check("dmem c3 state", state, 2);
    dmem_resp = 1;
    #1;
    check("dmem resp stall_mem", stall_mem, 0);
    tick();
    check("dmem back run", state, 0);
    check("dmem count", mem_stall_cnt, 3);
    // all hazards together: dmem wins, load-use acted on after the wait
    idle(); mem_dmem_req = 1; if_imem_req = 1; load_in_ex(9); id_uses_rs1 = 1; id_rs1_num = 9;
    #1;
    check("simul stall_mem", stall_mem, 1);
    check("simul bubble_ex", bubble_ex, 0);
    tick(2);
    dmem_resp = 1;
    #1;
    check("simul resp bubble_ex", bubble_ex, 0);
    tick();
    check("simul after bubble_ex", bubble_ex, 1);
    check("simul after bubble_id", bubble_id, 0);
    idle();
    tick();
    clear_counters();
    // saturation
    mem_dmem_req = 1;
    tick(20);
    dmem_resp = 1;
    tick();
    check("sat count", mem_stall_cnt, CMAX);
    idle(); perf_clr = 1; mem_dmem_req = 1;
    tick();
    check("clr priority", mem_stall_cnt, 0);
    perf_clr = 0;
    tick(2);
    check("mid-wait state", state, 2);
    // reset inside a wait returns to RUN at once
    rst_n = 0;
    #1;
    check("async rst state", state, 0);
    check("async rst stall_mem", stall_mem, 0);
    check("async rst count", mem_stall_cnt, 0);
    tick();
    rst_n = 1;
    idle();
    tick();
    // swept vectors over a small register window so hazards collide often
    for (int i = 0; i < 400; i++) begin
      id_rs1_num = 5'($urandom_range(0, 3));
      id_rs2_num = 5'($urandom_range(0, 3));
      ex_rd_num = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom); id_is_store = 1'($urandom);
      ex_load_regfile = 1'($urandom); ex_is_load = 1'($urandom);
      mem_dmem_req = 1'($urandom); dmem_resp = 1'($urandom);
      if_imem_req = 1'($urandom); imem_resp = 1'($urandom);
      perf_clr = ($urandom_range(0, 31) == 0);
      tick();
    end
    idle();
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
